// File: rtl/stream_from_dram_pkg.sv
// Shared constants for the strided DDR reader: register map, CTRL bit positions, FSM states.
package stream_from_dram_pkg;

  localparam logic [1:0] REG_BASE = 2'd0;
  localparam logic [1:0] REG_LEN  = 2'd1;
  localparam logic [1:0] REG_STEP = 2'd2;
  localparam logic [1:0] REG_CTRL = 2'd3;

  // CTRL write fields
  localparam int CTRL_START   = 0;
  localparam int CTRL_LOOP_WR = 1;

  // CTRL read fields
  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;
  localparam int STAT_LOOP = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/stream_from_dram_csr.sv
// Host register file: BASE/LEN/STEP storage, CTRL start/abort pulses, 1-cycle registered readback.
// Loop request only honoured when STREAM_FROM_DRAM_LOOP_EN is defined.
module stream_from_dram_csr
  import stream_from_dram_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        addr,
  input  logic              read,
  input  logic              write,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  input  logic              busy,
  input  logic              done,
  input  logic              loop_on,
  output logic [ADDR_W-1:0] base,
  output logic [CNT_W-1:0]  len,
  output logic [ADDR_W-1:0] step,
  output logic              start,
  output logic              abort,
  output logic              loop_req
);

  logic        ctrl_wr;
  logic [31:0] rd_mux;

  assign ctrl_wr = write && (addr == REG_CTRL);
  assign start   = ctrl_wr && writedata[CTRL_START];
  assign abort   = ctrl_wr && !writedata[CTRL_START];

`ifdef STREAM_FROM_DRAM_LOOP_EN
  assign loop_req = writedata[CTRL_LOOP_WR];
`else
  assign loop_req = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      base <= '0;
      len  <= '0;
      step <= '0;
    end else if (write) begin
      case (addr)
        REG_BASE: base <= ADDR_W'(writedata);
        REG_LEN:  len  <= CNT_W'(writedata);
        REG_STEP: step <= ADDR_W'(writedata);
        default:  ;
      endcase
    end
  end

  always_comb begin
    rd_mux = '0;
    case (addr)
      REG_BASE: rd_mux = 32'(base);
      REG_LEN:  rd_mux = 32'(len);
      REG_STEP: rd_mux = 32'(step);
      default: begin
        rd_mux[STAT_BUSY] = busy;
        rd_mux[STAT_DONE] = done;
        rd_mux[STAT_LOOP] = loop_on;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)       readdata <= '0;
    else if (read) readdata <= rd_mux;
  end

endmodule

// File: rtl/stream_from_dram.sv
// Strided Avalon-MM read master: pipelined reads, responses sign-extended to 32 bits one cycle later.
// Holds requests under ddr_waitrequest; output stream has no backpressure. Loop mode: STREAM_FROM_DRAM_LOOP_EN.
module stream_from_dram
  import stream_from_dram_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       ddr_readdata,
  input  logic              ddr_readdatavalid,
  input  logic              ddr_waitrequest,
  output logic [ADDR_W-1:0] ddr_addr,
  output logic              ddr_read,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  input  logic [1:0]        addr,
  input  logic              read,
  input  logic              write,
  output logic [31:0]       d_out,
  output logic              vout
);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] base, step, cfg_base, cfg_step, cur_addr;
  logic [CNT_W-1:0]  len, cfg_len, issued, rcvd;
  logic              start, abort, loop_req;
  logic              aborting, done, loop_on, busy;
  logic              accept, rsp;
  logic              do_load, do_restart, do_abort, set_done;

  stream_from_dram_csr #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) u_csr (
    .clk       (clk),
    .rst       (rst),
    .addr      (addr),
    .read      (read),
    .write     (write),
    .writedata (writedata),
    .readdata  (readdata),
    .busy      (busy),
    .done      (done),
    .loop_on   (loop_on),
    .base      (base),
    .len       (len),
    .step      (step),
    .start     (start),
    .abort     (abort),
    .loop_req  (loop_req)
  );

  assign busy     = (state != IDLE);
  assign ddr_read = (state == ISSUE);
  assign ddr_addr = cur_addr;
  assign accept   = ddr_read && !ddr_waitrequest;
  assign rsp      = ddr_readdatavalid && busy;

  always_comb begin
    state_nxt  = state;
    do_load    = 1'b0;
    do_restart = 1'b0;
    do_abort   = 1'b0;
    set_done   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (len != '0) begin
            do_load   = 1'b1;
            state_nxt = ISSUE;
          end else begin
            set_done = 1'b1;
          end
        end
      end
      ISSUE: begin
        if (abort) begin
          do_abort  = 1'b1;
          state_nxt = DRAIN;
        end else if (accept && (issued + CNT_W'(1) == cfg_len)) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        do_abort = abort && !aborting;
        // issued equals LEN here unless the run was cut short, so one compare covers both exits
        if (rcvd == issued) begin
          if (aborting || abort) begin
            state_nxt = IDLE;
          end else if (loop_on) begin
            do_restart = 1'b1;
            state_nxt  = ISSUE;
          end else begin
            set_done  = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cfg_base <= '0;
      cfg_step <= '0;
      cfg_len  <= '0;
      cur_addr <= '0;
      issued   <= '0;
      rcvd     <= '0;
      aborting <= 1'b0;
      done     <= 1'b0;
      loop_on  <= 1'b0;
      d_out    <= '0;
      vout     <= 1'b0;
    end else begin
      state <= state_nxt;
      // data already in flight at abort time is still counted but never presented
      vout  <= rsp && !aborting && !abort;
      if (rsp && !aborting && !abort)
        d_out <= {{16{ddr_readdata[15]}}, ddr_readdata};
      if (set_done)
        done <= 1'b1;
      if (do_load) begin
        cfg_base <= base;
        cfg_step <= step;
        cfg_len  <= len;
        cur_addr <= base;
        issued   <= '0;
        rcvd     <= '0;
        done     <= 1'b0;
        aborting <= 1'b0;
        loop_on  <= loop_req;
      end else if (do_restart) begin
        cur_addr <= cfg_base;
        issued   <= '0;
        rcvd     <= '0;
      end else begin
        if (accept) begin
          cur_addr <= cur_addr + cfg_step;
          issued   <= issued + CNT_W'(1);
        end
        if (rsp)
          rcvd <= rcvd + CNT_W'(1);
      end
      if (do_abort) begin
        aborting <= 1'b1;
        loop_on  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_stream_from_dram.sv
// Directed bench: 1-cycle-latency DDR responder with optional random stalls, host register tasks.
module tb_stream_from_dram;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] ddr_readdata;
  logic        ddr_readdatavalid, ddr_waitrequest;
  logic [31:0] ddr_addr;
  logic        ddr_read;
  logic [31:0] writedata, readdata;
  logic [1:0]  addr;
  logic        read, write;
  logic [31:0] d_out;
  logic        vout;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] mem [0:4095];
  logic [31:0] acc_q[$];
  int          acc_cyc[$];
  logic [31:0] out_q[$];
  int          cyc = 0;
  int          rd_hi = 0;
  bit          rand_wait = 1'b0;

  always #5 clk = ~clk;

  stream_from_dram #(.ADDR_W(32), .CNT_W(32)) dut (
    .clk               (clk),
    .rst               (rst),
    .ddr_readdata      (ddr_readdata),
    .ddr_readdatavalid (ddr_readdatavalid),
    .ddr_waitrequest   (ddr_waitrequest),
    .ddr_addr          (ddr_addr),
    .ddr_read          (ddr_read),
    .writedata         (writedata),
    .readdata          (readdata),
    .addr              (addr),
    .read              (read),
    .write             (write),
    .d_out             (d_out),
    .vout              (vout)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // DDR model and output monitor, all on the falling edge
  initial begin : responder
    logic        pend, stalled;
    logic [15:0] pdat;
    logic [31:0] saddr;
    pend = 1'b0; stalled = 1'b0; pdat = '0; saddr = '0;
    ddr_readdatavalid = 1'b0; ddr_readdata = '0; ddr_waitrequest = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      ddr_readdatavalid = pend;
      ddr_readdata      = pend ? pdat : 16'h0;
      if (vout) out_q.push_back(d_out);
      if (stalled && rand_wait)
        check("stall_hold", {31'b0, ddr_read, ddr_addr}, {31'b0, 1'b1, saddr});
      ddr_waitrequest = rand_wait ? ($urandom_range(0, 2) == 0) : 1'b0;
      if (ddr_read) rd_hi++;
      pend    = ddr_read && !ddr_waitrequest;
      stalled = ddr_read && ddr_waitrequest;
      saddr   = ddr_addr;
      if (pend) begin
        pdat = mem[ddr_addr[11:0]];
        acc_q.push_back(ddr_addr);
        acc_cyc.push_back(cyc);
      end
    end
  end

  task automatic csr_wr(input logic [1:0] a, input logic [31:0] d);
    addr = a; writedata = d; write = 1'b1;
    @(negedge clk);
    write = 1'b0;
  endtask

  task automatic csr_rd(input logic [1:0] a, output logic [31:0] d);
    addr = a; read = 1'b1;
    @(negedge clk);
    read = 1'b0;
    d = readdata;
  endtask

  task automatic cfg(input logic [31:0] b, input logic [31:0] l, input logic [31:0] s);
    csr_wr(2'd0, b);
    csr_wr(2'd1, l);
    csr_wr(2'd2, s);
  endtask

  task automatic clear_q();
    acc_q.delete(); acc_cyc.delete(); out_q.delete();
  endtask

  task automatic wait_idle(input string tag, input int max, output logic [31:0] st);
    st = 32'hFFFF_FFFF;
    for (int i = 0; i < max; i++) begin
      csr_rd(2'd3, st);
      if (!st[0]) break;
    end
    check({tag, "_idle"}, st[0], 1'b0);
  endtask

  task automatic wait_cnt(input string tag, input bit use_out, input int n, input int max);
    int got;
    got = 0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      got = use_out ? out_q.size() : acc_q.size();
      if (got >= n) break;
    end
    check({tag, "_reached"}, got >= n, 1'b1);
  endtask

  initial begin : main
    logic [31:0] v;
    int          bad, snap;

    for (int i = 0; i < 4096; i++) mem[i] = i[15:0];
    rst = 1'b1; read = 1'b0; write = 1'b0; addr = '0; writedata = '0;
    repeat (3) @(negedge clk);

    check("rst_ddr_read", ddr_read, 1'b0);
    check("rst_ddr_addr", ddr_addr, 32'h0);
    check("rst_vout", vout, 1'b0);
    check("rst_d_out", d_out, 32'h0);
    check("rst_readdata", readdata, 32'h0);
    rst = 1'b0;
    for (int r = 0; r < 4; r++) begin
      csr_rd(r[1:0], v);
      check($sformatf("rst_reg%0d", r), v, 32'h0);
    end

    // basic: 2900 back-to-back reads from 100
    clear_q();
    cfg(100, 2900, 1);
    csr_wr(2'd3, 32'h1);
    wait_idle("basic", 10000, v);
    check("basic_ctrl", v, 32'h2);
    check("basic_n_req", acc_q.size(), 2900);
    check("basic_n_out", out_q.size(), 2900);
    bad = 0;
    for (int i = 0; i < acc_q.size(); i++) if (acc_q[i] !== 32'(100 + i)) bad++;
    for (int i = 0; i < out_q.size(); i++) if (out_q[i] !== 32'(100 + i)) bad++;
    check("basic_seq_err", bad, 0);
    check("basic_b2b", (acc_cyc.size() > 0) ? acc_cyc[acc_cyc.size() - 1] - acc_cyc[0] : -1, 2899);

    // stride 3 with random stalls
    clear_q();
    rand_wait = 1'b1;
    cfg(0, 5, 3);
    csr_wr(2'd3, 32'h1);
    wait_idle("stride", 300, v);
    rand_wait = 1'b0;
    check("stride_ctrl", v, 32'h2);
    check("stride_n_req", acc_q.size(), 5);
    check("stride_n_out", out_q.size(), 5);
    for (int i = 0; i < acc_q.size(); i++) check($sformatf("stride_addr%0d", i), acc_q[i], 32'(3 * i));
    for (int i = 0; i < out_q.size(); i++) check($sformatf("stride_out%0d", i), out_q[i], 32'(3 * i));

    // sign extension
    clear_q();
    mem[200] = 16'hFFFE;
    mem[201] = 16'h7FFF;
    cfg(200, 2, 1);
    csr_wr(2'd3, 32'h1);
    wait_idle("sign", 100, v);
    check("sign_n_out", out_q.size(), 2);
    check("sign_neg", (out_q.size() > 0) ? out_q[0] : 32'hx, 32'hFFFF_FFFE);
    check("sign_pos", (out_q.size() > 1) ? out_q[1] : 32'hx, 32'h0000_7FFF);

    // abort after 10 samples of a 100-sample run
    clear_q();
    cfg(500, 100, 1);
    csr_wr(2'd3, 32'h1);
    wait_cnt("abort", 1'b1, 10, 300);
    csr_wr(2'd3, 32'h0);
    #1 snap = out_q.size();
    wait_idle("abort", 300, v);
    check("abort_ctrl", v, 32'h0);
    check("abort_min10", snap >= 10, 1'b1);
    check("abort_cut", snap < 100, 1'b1);
    repeat (10) @(negedge clk);
    check("abort_no_more", out_q.size(), snap);
    bad = 0;
    for (int i = 0; i < out_q.size(); i++) if (out_q[i] !== 32'(500 + i)) bad++;
    check("abort_seq_err", bad, 0);

    // zero length: done must come back without any traffic
    clear_q();
    rd_hi = 0;
    csr_wr(2'd1, 32'h0);
    csr_wr(2'd3, 32'h1);
    repeat (5) @(negedge clk);
    csr_rd(2'd3, v);
    check("zero_ctrl", v, 32'h2);
    check("zero_rd", rd_hi, 0);
    check("zero_out", out_q.size(), 0);

    // reset mid-run
    clear_q();
    cfg(1000, 100, 1);
    csr_wr(2'd3, 32'h1);
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_ddr_read", ddr_read, 1'b0);
    check("mid_rst_ddr_addr", ddr_addr, 32'h0);
    check("mid_rst_vout", vout, 1'b0);
    check("mid_rst_d_out", d_out, 32'h0);
    check("mid_rst_readdata", readdata, 32'h0);
    rst = 1'b0;
    snap = out_q.size();
    repeat (5) @(negedge clk);
    check("mid_rst_ignore", out_q.size(), snap);
    csr_rd(2'd3, v);
    check("mid_rst_ctrl", v, 32'h0);
    csr_rd(2'd0, v);
    check("mid_rst_base", v, 32'h0);

    // loop request
    clear_q();
    cfg(8, 4, 1);
    csr_wr(2'd3, 32'h3);
`ifdef STREAM_FROM_DRAM_LOOP_EN
    csr_rd(2'd3, v);
    check("loop_ctrl", v, 32'h5);
    wait_cnt("loop", 1'b0, 10, 300);
    csr_wr(2'd3, 32'h0);
    for (int i = 0; i < 10 && i < acc_q.size(); i++)
      check($sformatf("loop_addr%0d", i), acc_q[i], 32'(8 + (i % 4)));
    wait_idle("loop", 300, v);
    check("loop_abort_ctrl", v[1:0], 2'b00);
    bad = 0;
    for (int i = 0; i < out_q.size(); i++) if (out_q[i] !== 32'(8 + (i % 4))) bad++;
    check("loop_out_err", bad, 0);
`else
    wait_idle("noloop", 100, v);
    check("noloop_ctrl", v, 32'h2);
    check("noloop_n_req", acc_q.size(), 4);
    check("noloop_n_out", out_q.size(), 4);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/stream_from_dram.md
Name: stream_from_dram

Overview:
- Avalon-MM read master that streams a strided block of 16-bit samples from DDR3 and presents them as a 32-bit sign-extended valid-qualified stream.
- Configured and started by a host through a 4-register Avalon-MM slave.
- Sits between the DDR3 controller port and downstream DSP.

Parameters:
- ADDR_W, 32, width of ddr_addr (word address).
- CNT_W, 32, width of the sample-count and outstanding-read counters.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- ddr_readdata  in  16  signed sample from DDR.
- ddr_readdatavalid  in  1  ddr_readdata valid this cycle.
- ddr_waitrequest  in  1  DDR stall; the read request is not accepted while high.
- ddr_addr  out  ADDR_W  word address of the current read request.
- ddr_read  out  1  read request.
- writedata  in  32  slave write data.
- readdata  out  32  slave read data.
- addr  in  2  slave register select.
- read  in  1  slave read strobe.
- write  in  1  slave write strobe.
- d_out  out  32  signed sample, sign-extended from 16 bits.
- vout  out  1  d_out valid, one-cycle pulse per sample.

Behaviour:
- Registers:
  - 0 BASE: start word address.
  - 1 LEN: sample count.
  - 2 STEP: address increment, unsigned, wraps modulo 2^ADDR_W.
  - 3 CTRL: write bit0=1 starts; write bit0=0 while busy aborts.
  - CTRL read: bit0 busy, bit1 done (sticky), bit2 loop (feature), others 0.
- Slave reads have a latency of 1: readdata is registered on the cycle after read=1.
- BASE, LEN and STEP are always writable. A run uses copies latched at start, so mid-run writes do not affect the current run.
- Reset: all registers, counters and status are 0; ddr_read=0, ddr_addr=0, d_out=0, vout=0, readdata=0.
- FSM states:
  - IDLE: start with LEN!=0 latches the config, sets cur_addr=BASE, issued=0, rcvd=0, clears done and moves to ISSUE. Start with LEN=0 sets done and stays in IDLE. Start while busy is ignored.
  - ISSUE: ddr_read=1 and ddr_addr=cur_addr.
    - A request is accepted on any cycle with ddr_read & !ddr_waitrequest. On acceptance: cur_addr += STEP, issued++.
    - When issued reaches LEN, deassert ddr_read the following cycle and go to DRAIN.
    - Reads are pipelined with no limit on outstanding requests.
  - DRAIN: wait until rcvd==LEN, then set done and return to IDLE.
- Each ddr_readdatavalid cycle (in ISSUE or DRAIN):
  - d_out <= sign-extended ddr_readdata and vout <= 1 on the next edge (1-cycle latency); rcvd++.
  - Responses arrive in request order.
- vout is 0 on all other cycles. readdatavalid in IDLE is ignored.
- Abort:
  - Stop issuing immediately.
  - Suppress vout for in-flight data but still count it.
  - Go to IDLE when rcvd==issued; done stays 0.
- Reset mid-run returns to IDLE at once. Any in-flight DDR data that arrives afterwards is ignored.
- A start write and ddr_readdatavalid in the same cycle are independent; the start is processed.

Optional Feature:
- Macro: STREAM_FROM_DRAM_LOOP_EN.
- With the macro: CTRL bit1 written together with start enables loop mode. When rcvd reaches LEN, the block restarts from BASE without returning to IDLE. Done is never set; busy stays 1 until abort. CTRL bit2 reads back the loop flag.
- Without the macro: CTRL bit1 is ignored, CTRL bit2 reads 0, and only single runs are supported.

Decomposition:
- Package stream_from_dram_pkg holds:
  - register index constants REG_BASE=0, REG_LEN=1, REG_STEP=2, REG_CTRL=3;
  - CTRL bit positions;
  - the FSM state enum (IDLE, ISSUE, DRAIN).
- One natural sub-module: stream_from_dram_csr, the slave register file with start/abort pulse generation.
- The read master FSM and the datapath stay in the top level.

Test Plan:
- Basic run:
  - Stimulus: mem[i]=i; BASE=100, LEN=2900, STEP=1, start; zero-wait memory with 1-cycle latency.
  - Response: ddr_addr 100..2999 issued back-to-back; exactly 2900 vout pulses with d_out=100..2999 in order; CTRL reads busy=0, done=1.
- Stride and stall:
  - Stimulus: BASE=0, LEN=5, STEP=3; waitrequest high on random cycles.
  - Response: addresses 0,3,6,9,12 each held until accepted; 5 outputs, no duplicates.
- Sign extension:
  - Stimulus: sample 16'hFFFE.
  - Response: d_out=32'hFFFFFFFE; sample 16'h7FFF gives d_out=32'h00007FFF.
- Zero length:
  - Stimulus: LEN=0, start.
  - Response: no ddr_read, no vout, done=1 on the next CTRL read.
- Abort and reset:
  - Stimulus: abort after 10 samples of a LEN=100 run.
  - Response: no further vout, busy drops once outstanding reads drain, done=0.
  - Stimulus: rst mid-run.
  - Response: all outputs 0 on the next cycle.
- Loop (STREAM_FROM_DRAM_LOOP_EN defined):
  - Stimulus: LEN=4, STEP=1, BASE=8, loop start.
  - Response: addresses repeat 8,9,10,11,8,… until abort.
